// File: rtl/toggle_cover_pkg.sv
// Shared types and width helpers for the toggle-cover reporter.
package toggle_cover_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int unsigned idx_w(input int unsigned total);
    return (total < 2) ? 1 : $clog2(total);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // Width of a bit position inside a WIDTH-bit vector (at least 1).
  function automatic int unsigned pos_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/toggle_cover_prio_enc.sv
// Combinational lowest-set-bit encoder used to pick the next pending cover point.
module toggle_cover_prio_enc
  import toggle_cover_pkg::*;
#(
  parameter int unsigned WIDTH = 42
) (
  input  logic [WIDTH-1:0]        vector,
  output logic                    any,
  output logic [pos_w(WIDTH)-1:0] pos
);

  localparam int unsigned POS_W = pos_w(WIDTH);

  // Scan from the top so the lowest set bit is the last (winning) assignment.
  always_comb begin
    any = |vector;
    pos = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (vector[i]) pos = POS_W'(i);
    end
  end

endmodule

// File: rtl/toggle_cover_reporter.sv
// Toggle-cover hit sink: sticky/pending bitmaps streamed out as global indices.
// Optional macro TOGGLE_COVER_DEDUP_EN reports each point only once until clear/reset.
module toggle_cover_reporter
  import toggle_cover_pkg::*;
#(
  parameter int unsigned WIDTH       = 42,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned COVER_TOTAL = 8940,
  parameter int unsigned IDX_W       = idx_w(COVER_TOTAL)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cover_en,
  input  logic [WIDTH-1:0]        valid,
  input  logic                    clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_index,
  output logic [cnt_w(WIDTH)-1:0] hit_count,
  output logic                    busy
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);
  localparam int unsigned POS_W = pos_w(WIDTH);

  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_err
    $error("toggle_cover_reporter: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
  end

  state_t             state, state_next;
  logic [WIDTH-1:0]   sticky, sticky_next;
  logic [WIDTH-1:0]   pending, pending_next;
  logic [POS_W-1:0]   sel_pos, sel_pos_next;
  logic               out_valid_next;
  logic [IDX_W-1:0]   out_index_next;
  logic [CNT_W-1:0]   hit_count_next;
  logic               busy_next;

  logic               enc_any;
  logic [POS_W-1:0]   enc_pos;
  logic [WIDTH-1:0]   hit;
  logic [WIDTH-1:0]   set_mask;
  logic [WIDTH-1:0]   release_mask;
  logic               handshake;
  logic [CNT_W-1:0]   popcnt;

  toggle_cover_prio_enc #(
    .WIDTH (WIDTH)
  ) u_prio_enc (
    .vector (pending),
    .any    (enc_any),
    .pos    (enc_pos)
  );

  // Next-state, bitmap and output computation.
  always_comb begin
    state_next     = state;
    sticky_next    = sticky;
    pending_next   = pending;
    sel_pos_next   = sel_pos;
    out_valid_next = out_valid;
    out_index_next = out_index;
    release_mask   = '0;

    hit       = cover_en ? valid : '0;
    handshake = (state == SEND) && out_valid && out_ready;

`ifdef TOGGLE_COVER_DEDUP_EN
    set_mask = hit & ~sticky;
`else
    set_mask = hit;
`endif

    popcnt = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      popcnt = popcnt + CNT_W'(sticky[i]);
    end
    hit_count_next = popcnt;

    case (state)
      IDLE: begin
        if (enc_any) begin
          sel_pos_next   = enc_pos;
          out_index_next = IDX_W'(COVER_INDEX) + IDX_W'(enc_pos);
          out_valid_next = 1'b1;
          state_next     = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          release_mask   = WIDTH'(1) << sel_pos;
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A new hit re-arms a point in the same cycle its report is accepted.
    sticky_next  = sticky | hit;
    pending_next = (pending & ~release_mask) | set_mask;

    if (clear) begin
      sticky_next    = '0;
      pending_next   = '0;
      hit_count_next = '0;
      out_valid_next = 1'b0;
      state_next     = IDLE;
    end

    busy_next = (pending_next != '0) || out_valid_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sticky    <= '0;
      pending   <= '0;
      sel_pos   <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      hit_count <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      sticky    <= sticky_next;
      pending   <= pending_next;
      sel_pos   <= sel_pos_next;
      out_valid <= out_valid_next;
      out_index <= out_index_next;
      hit_count <= hit_count_next;
      busy      <= busy_next;
    end
  end

endmodule
